// File: rtl/regfile_mp_if.sv
// Register file bus: write ports, read ports, clear handshake, collision flag
// and the optional scoreboard signals (alloc_en/alloc_addr/rd_busy).
//   master : datapath side (drives writes, read addresses, clr_req, alloc)
//   slave  : register file side (drives ready, rd_data, wr_collide, rd_busy)
// Packed multi-port fields put port j at [j*W +: W].
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);
  localparam int AW = $clog2(NREG);

  logic                clr_req;
  logic                ready;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wr_collide;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NRD-1:0]      rd_busy;

  modport master (
    output clr_req, wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr,
    input  ready, rd_data, wr_collide, rd_busy
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr,
    output ready, rd_data, wr_collide, rd_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   NRD combinational read ports with same-cycle write bypass, NWR synchronous
//   write ports (highest port index wins on a shared address), and a clear
//   sequencer that zeroes one entry per cycle after reset or on clr_req.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset (restarts the clear sweep)
//   bus      regfile_mp_if.slave: clr_req/ready, wr_*, rd_*, wr_collide,
//            alloc_en/alloc_addr/rd_busy
// Optional feature macro REGFILE_SCOREBOARD_EN: per-register busy bits set by
//   alloc_en and cleared by committed writes, reported per read port on
//   rd_busy. When undefined, rd_busy is tied 0 and alloc inputs are ignored.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int NRD       = 2,
  parameter int NWR       = 1,
  parameter int ZERO_REG0 = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  regfile_mp_if.slave   bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              clr_ptr_q, clr_ptr_d;
  logic                       wr_collide_q, wr_collide_d;
  logic [XLEN-1:0]            mem_q [NREG];
  logic [XLEN-1:0]            mem_d [NREG];

  logic                       run;
  logic [NWR-1:0][AW-1:0]     wa;
  logic [NWR-1:0][XLEN-1:0]   wd;
  logic [NWR-1:0]             we_eff;
  logic [NRD-1:0][AW-1:0]     ra;
  logic [NRD-1:0][XLEN-1:0]   rdv;
  logic [NRD-1:0]             byp;

  assign run            = (state_q == S_RUN);
  assign wa             = bus.wr_addr;
  assign wd             = bus.wr_data;
  assign ra             = bus.rd_addr;
  assign bus.ready      = run;
  assign bus.wr_collide = wr_collide_q;
  assign bus.rd_data    = rdv;

  // Effective write: only in RUN, and address-0 writes vanish when reg 0 is hardwired.
  always_comb begin
    we_eff = '0;
    for (int j = 0; j < NWR; j++)
      we_eff[j] = run & bus.wr_en[j] & ~((ZERO_REG0 != 0) && (wa[j] == '0));
  end

  // Clear sequencer
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(NREG - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.clr_req) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_CLEAR;
      clr_ptr_q    <= '0;
      wr_collide_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      wr_collide_q <= wr_collide_d;
    end
  end

  // Array update: ascending port order makes the highest index win.
  always_comb begin
    mem_d = mem_q;
    if (!run) mem_d[clr_ptr_q] = '0;
    else
      for (int j = 0; j < NWR; j++)
        if (we_eff[j]) mem_d[wa[j]] = wd[j];
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_comb begin
    wr_collide_d = 1'b0;
    for (int a = 0; a < NWR; a++)
      for (int b = a + 1; b < NWR; b++)
        if (we_eff[a] && we_eff[b] && (wa[a] == wa[b])) wr_collide_d = 1'b1;
  end

  // Reads with write-before-read bypass; gated to 0 while clearing.
  always_comb begin
    rdv = '0;
    byp = '0;
    for (int i = 0; i < NRD; i++) begin
      rdv[i] = mem_q[ra[i]];
      for (int j = 0; j < NWR; j++)
        if (we_eff[j] && (wa[j] == ra[i])) begin
          rdv[i] = wd[j];
          byp[i] = 1'b1;
        end
      if (!run || ((ZERO_REG0 != 0) && (ra[i] == '0))) rdv[i] = '0;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;

  // Write clears, then alloc sets, so a same-cycle alloc keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (bus.clr_req) busy_d = '0;
      else begin
        for (int j = 0; j < NWR; j++)
          if (we_eff[j]) busy_d[wa[j]] = 1'b0;
        if (bus.alloc_en) busy_d[bus.alloc_addr] = 1'b1;
        if (ZERO_REG0 != 0) busy_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  always_comb begin
    bus.rd_busy = '0;
    for (int i = 0; i < NRD; i++)
      bus.rd_busy[i] = run & busy_q[ra[i]] & ~byp[i];
  end
`else
  assign bus.rd_busy = '0;
  logic unused_sb;
  assign unused_sb = ^{bus.alloc_en, bus.alloc_addr};
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NREG=32, NRD=2, NWR=2, ZERO_REG0=1):
// reset sweep length, table-driven write/read/bypass/collision vectors,
// clear request interrupted by reset, and scoreboard busy behaviour.
module tb_regfile_mp;
  localparam int XLEN = 32, NREG = 32, NRD = 2, NWR = 2, AW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG0(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  we;
    int          wa0, wa1;
    logic [31:0] wd0, wd1;
    int          ra0, ra1;
    logic [31:0] e0, e1;
    logic        ecol;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.clr_req  = 1'b0;
    bus.alloc_en = 1'b0;
  endtask

  task automatic setrd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.ready && cnt < 200);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NREG; a += 2) begin
      setrd(a, a + 1);
      #1;
      chk($sformatf("%s_r%0d", tag, a), bus.rd_data[31:0], 32'h0);
      chk($sformatf("%s_r%0d", tag, a + 1), bus.rd_data[63:32], 32'h0);
    end
  endtask

  initial begin
    int cnt;
    // we, wa0, wa1, wd0, wd1, ra0, ra1, e0, e1, ecol
    vt[0]  = '{2'b01, 5, 0, 32'hDEADBEEF, 32'h0, 5, 6, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1]  = '{2'b00, 0, 0, 32'h0, 32'h0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{2'b01, 0, 0, 32'h1234, 32'h0, 0, 5, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1'b0};
    vt[4]  = '{2'b11, 7, 7, 32'h11, 32'h22, 7, 5, 32'h22, 32'hDEADBEEF, 1'b1};
    vt[5]  = '{2'b00, 0, 0, 32'h0, 32'h0, 7, 7, 32'h22, 32'h22, 1'b0};
    vt[6]  = '{2'b11, 0, 0, 32'h55, 32'h66, 0, 7, 32'h0, 32'h22, 1'b0};
    vt[7]  = '{2'b11, 3, 4, 32'hAAAA, 32'hBBBB, 3, 4, 32'hAAAA, 32'hBBBB, 1'b0};
    vt[8]  = '{2'b01, 3, 3, 32'hCCCC, 32'hFFFF, 3, 3, 32'hCCCC, 32'hCCCC, 1'b0};
    vt[9]  = '{2'b10, 0, 31, 32'h0, 32'h80000001, 31, 4, 32'h80000001, 32'hBBBB, 1'b0};
    vt[10] = '{2'b00, 0, 0, 32'h0, 32'h0, 31, 3, 32'h80000001, 32'hCCCC, 1'b0};

    idle();
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_addr    = '0;
    bus.alloc_addr = '0;

    // Reset and initial sweep
    reset_n = 1'b0;
    tick();
    tick();
    chk("reset_ready", {31'h0, bus.ready}, 32'h0);
    chk("reset_collide", {31'h0, bus.wr_collide}, 32'h0);
    chk("reset_rd0", bus.rd_data[31:0], 32'h0);
    reset_n = 1'b1;
    wait_ready(cnt);
    chk("reset_sweep_len", cnt, NREG);
    check_all_zero("init");

    // Table-driven write/read/bypass/collision vectors
    for (int i = 0; i < 11; i++) begin
      bus.wr_en   = vt[i].we;
      bus.wr_addr = {AW'(vt[i].wa1), AW'(vt[i].wa0)};
      bus.wr_data = {vt[i].wd1, vt[i].wd0};
      setrd(vt[i].ra0, vt[i].ra1);
      #1;
      chk($sformatf("v%0d_rd0", i), bus.rd_data[31:0], vt[i].e0);
      chk($sformatf("v%0d_rd1", i), bus.rd_data[63:32], vt[i].e1);
      tick();
      chk($sformatf("v%0d_collide", i), {31'h0, bus.wr_collide}, {31'h0, vt[i].ecol});
    end
    idle();

    // Fill, clear request, reset in the middle of the sweep
    for (int a = 0; a < NREG; a += 2) begin
      bus.wr_en   = 2'b11;
      bus.wr_addr = {AW'(a + 1), AW'(a)};
      bus.wr_data = {32'hA5A5A5A5, 32'hA5A5A5A5};
      tick();
    end
    idle();
    setrd(1, 31);
    #1;
    chk("fill_r1", bus.rd_data[31:0], 32'hA5A5A5A5);
    chk("fill_r31", bus.rd_data[63:32], 32'hA5A5A5A5);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    chk("clr_ready", {31'h0, bus.ready}, 32'h0);
    repeat (10) tick();
    chk("clr_mid_ready", {31'h0, bus.ready}, 32'h0);
    chk("clr_mid_rd31", bus.rd_data[63:32], 32'h0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wait_ready(cnt);
    chk("restart_sweep_len", cnt, NREG);
    check_all_zero("restart");

`ifdef REGFILE_SCOREBOARD_EN
    setrd(9, 8);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(9);
    tick();
    bus.alloc_en = 1'b0;
    #1;
    chk("sb_alloc_busy", {30'h0, bus.rd_busy}, 32'h1);
    bus.wr_en   = 2'b01;
    bus.wr_addr = {AW'(0), AW'(9)};
    bus.wr_data = {32'h0, 32'h99};
    #1;
    chk("sb_bypass_busy", {30'h0, bus.rd_busy}, 32'h0);
    chk("sb_bypass_data", bus.rd_data[31:0], 32'h99);
    tick();
    idle();
    #1;
    chk("sb_after_write", {30'h0, bus.rd_busy}, 32'h0);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(8);
    bus.wr_en      = 2'b01;
    bus.wr_addr    = {AW'(0), AW'(8)};
    tick();
    idle();
    #1;
    chk("sb_alloc_wins", {30'h0, bus.rd_busy}, 32'h2);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    wait_ready(cnt);
    chk("sb_clr_sweep_len", cnt, NREG);
    chk("sb_clr_busy", {30'h0, bus.rd_busy}, 32'h0);
`else
    setrd(9, 9);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(9);
    tick();
    bus.alloc_en = 1'b0;
    #1;
    chk("nosb_busy", {30'h0, bus.rd_busy}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
